// File: rtl/zpu_periph_pkg.sv
// -----------------------------------------------------------------------------
// zpu_periph_pkg
// Shared definitions for the ZPU Wishbone peripheral: register offsets
// (word index taken from adr[4:2]), CTRL/STATUS bit positions, the
// TIMER_CMP reset value and a byte-lane merge helper for partial writes.
// -----------------------------------------------------------------------------
package zpu_periph_pkg;

  // Word offsets within the peripheral, decoded from wb_adr[4:2].
  typedef enum logic [2:0] {
    REG_GPIO_OUT  = 3'd0,
    REG_GPIO_DIR  = 3'd1,
    REG_GPIO_IN   = 3'd2,
    REG_TIMER_CNT = 3'd3,
    REG_TIMER_CMP = 3'd4,
    REG_CTRL      = 3'd5,
    REG_STATUS    = 3'd6,
    REG_RESERVED  = 3'd7
  } reg_addr_e;

  // CTRL register layout.
  localparam int CTRL_W           = 3;
  localparam int CTRL_EN_BIT      = 0;  // timer enable
  localparam int CTRL_AUTOCLR_BIT = 1;  // load 0 on match instead of +1
  localparam int CTRL_IRQEN_BIT   = 2;  // route STATUS match flag to irq

  // STATUS register layout (write-one-to-clear).
  localparam int STATUS_MATCH_BIT = 0;

  localparam logic [31:0] TIMER_CMP_RESET = 32'hFFFF_FFFF;

  // Replace the byte lanes of old_val selected by sel with new_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] mask;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/zpu_sync_bus.sv
// -----------------------------------------------------------------------------
// zpu_sync_bus
// Multi-flop synchroniser for a bus of independent asynchronous bits.
// Each bit passes through DEPTH flops; no cross-bit coherency is implied.
//
// Ports:
//   clk  - sampling clock (rising edge)
//   rst  - synchronous, active-high; clears every stage
//   i_d  - asynchronous input bits
//   o_q  - synchronised bits (output of the last stage)
// Parameters: WIDTH (bus width), DEPTH (number of stages, 2..3 expected)
// -----------------------------------------------------------------------------
module zpu_sync_bus #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // NOTE: these are individual flops, not a RAM, so resetting every stage is
  // cheap and keeps GPIO_IN deterministic straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/zpu_wb_periph.sv
// -----------------------------------------------------------------------------
// zpu_wb_periph
// Wishbone (pipelined mode, never stalls) peripheral with 32 GPIO bits and a
// 32-bit compare timer that raises a level interrupt.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   wb_adr              - byte address, only [4:2] decoded
//   wb_dat_in/out       - write data / read data (0 unless wb_ack)
//   wb_sel              - byte enables for writes
//   wb_cyc, wb_stb,
//   wb_we               - bus cycle, strobe, write enable
//   wb_ack              - one-cycle ack, one cycle after each accepted strobe
//   wb_stall            - constant 0
//   gpioin              - asynchronous pin inputs
//   gpioout, gpiodir    - pin output levels and drive enables (1 = drive)
//   irq                 - registered timer interrupt (STATUS[0] & CTRL[2])
// Parameters: RESET_DIR (GPIO_DIR reset value), SYNC_STAGES (2..3)
// -----------------------------------------------------------------------------
module zpu_wb_periph
  import zpu_periph_pkg::*;
#(
  parameter logic [31:0] RESET_DIR   = 32'h0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_in,
  output logic [31:0] wb_dat_out,
  input  logic [3:0]  wb_sel,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  output logic        wb_ack,
  output logic        wb_stall,
  input  logic [31:0] gpioin,
  output logic [31:0] gpioout,
  output logic [31:0] gpiodir,
  output logic        irq
);

  // Register state.
  logic [31:0]       r_gpio_out;
  logic [31:0]       r_gpio_dir;
  logic [31:0]       r_cnt;
  logic [31:0]       r_cmp;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_status;
  logic              r_irq;
  logic              r_ack_pend;  // a strobe was accepted last cycle
  logic [31:0]       r_rdata;     // read data captured at accept

  logic [31:0] w_gpio_in;
  logic        w_accept;
  logic        w_wr;
  reg_addr_e   w_reg;
  logic        w_match;
  logic        w_w1c;
  logic [31:0] w_rdata;
  logic [31:0] w_cnt_next;
  logic        w_unused_bits;

  // Address bits outside [4:2] and read-side byte enables are don't-care.
  assign w_unused_bits = ^{wb_adr[31:5], wb_adr[1:0]};

  zpu_sync_bus #(
    .WIDTH (32),
    .DEPTH (SYNC_STAGES)
  ) u_gpio_sync (
    .clk (clk),
    .rst (rst),
    .i_d (gpioin),
    .o_q (w_gpio_in)
  );

  assign w_accept = wb_cyc & wb_stb & ~rst;
  assign w_wr     = w_accept & wb_we;
  assign w_reg    = reg_addr_e'(wb_adr[4:2]);
  assign w_match  = r_ctrl[CTRL_EN_BIT] & (r_cnt == r_cmp);
  assign w_w1c    = w_wr && (w_reg == REG_STATUS) && wb_sel[0]
                    && wb_dat_in[STATUS_MATCH_BIT];

  // Register read mux, sampled at accept time.
  always_comb begin
    // NOTE: default assignment first, so no path leaves w_rdata unassigned
    // and no latch is inferred.
    w_rdata = '0;
    case (w_reg)
      REG_GPIO_OUT:  w_rdata = r_gpio_out;
      REG_GPIO_DIR:  w_rdata = r_gpio_dir;
      REG_GPIO_IN:   w_rdata = w_gpio_in;
      REG_TIMER_CNT: w_rdata = r_cnt;
      REG_TIMER_CMP: w_rdata = r_cmp;
      REG_CTRL:      w_rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
      REG_STATUS:    w_rdata = {31'd0, r_status};
      default:       w_rdata = '0;
    endcase
  end

  // Counter priority: bus write, then auto-clear on match, then increment.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_wr && (w_reg == REG_TIMER_CNT)) begin
      w_cnt_next = byte_merge(r_cnt, wb_dat_in, wb_sel);
    end else if (r_ctrl[CTRL_EN_BIT]) begin
      w_cnt_next = (w_match && r_ctrl[CTRL_AUTOCLR_BIT]) ? '0 : r_cnt + 32'd1;
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpio_out <= '0;
      r_gpio_dir <= RESET_DIR;
      r_cnt      <= '0;
      r_cmp      <= TIMER_CMP_RESET;
      r_ctrl     <= '0;
      r_status   <= 1'b0;
      r_irq      <= 1'b0;
      r_ack_pend <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_ack_pend <= w_accept;
      if (w_accept) r_rdata <= wb_we ? '0 : w_rdata;

      r_cnt <= w_cnt_next;

      if (w_wr) begin
        case (w_reg)
          REG_GPIO_OUT:  r_gpio_out <= byte_merge(r_gpio_out, wb_dat_in, wb_sel);
          REG_GPIO_DIR:  r_gpio_dir <= byte_merge(r_gpio_dir, wb_dat_in, wb_sel);
          REG_TIMER_CMP: r_cmp      <= byte_merge(r_cmp, wb_dat_in, wb_sel);
          REG_CTRL:      if (wb_sel[0]) r_ctrl <= wb_dat_in[CTRL_W-1:0];
          default:       ;
        endcase
      end

      // A match in the same cycle as a W1C keeps the flag set.
      if (w_match)    r_status <= 1'b1;
      else if (w_w1c) r_status <= 1'b0;

      r_irq <= r_status & r_ctrl[CTRL_IRQEN_BIT];
    end
  end

  // NOTE: the ack is gated combinationally by wb_cyc (and rst) so a master
  // that abandons the cycle, or a reset, drops a pending ack immediately.
  assign wb_ack     = r_ack_pend & wb_cyc & ~rst;
  assign wb_dat_out = wb_ack ? r_rdata : '0;
  assign wb_stall   = 1'b0;
  assign gpioout    = r_gpio_out;
  assign gpiodir    = r_gpio_dir;
  assign irq        = r_irq;

endmodule

// File: tb/tb_zpu_wb_periph.sv
// -----------------------------------------------------------------------------
// tb_zpu_wb_periph
// Directed scenarios followed by randomized bus traffic, all compared every
// cycle against a register-level reference model of the peripheral.
// -----------------------------------------------------------------------------
module tb_zpu_wb_periph;

  localparam logic [31:0] RDIR  = 32'h0000_FF00;
  localparam int          SYNC  = 2;

  localparam logic [2:0] A_OUT = 3'd0, A_DIR = 3'd1, A_IN  = 3'd2, A_CNT = 3'd3,
                         A_CMP = 3'd4, A_CTL = 3'd5, A_STS = 3'd6, A_RSV = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr, wb_dat_in, wb_dat_out;
  logic [3:0]  wb_sel;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_stall;
  logic [31:0] gpioin, gpioout, gpiodir;
  logic        irq;

  zpu_wb_periph #(.RESET_DIR(RDIR), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .wb_adr(wb_adr), .wb_dat_in(wb_dat_in),
    .wb_dat_out(wb_dat_out), .wb_sel(wb_sel), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_ack(wb_ack), .wb_stall(wb_stall), .gpioin(gpioin),
    .gpioout(gpioout), .gpiodir(gpiodir), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acks  = 0;

  logic [31:0] last_dat;
  logic        last_ack;
  logic        last_irq;
  logic [31:0] pins = '0;

  // Reference model: architectural register values.
  logic [31:0] m_out, m_dir, m_cnt, m_cmp, m_rdata;
  logic [2:0]  m_ctrl;
  logic        m_status, m_irq, m_pend;
  logic [31:0] m_sync [$];  // pin values sampled at the last SYNC edges

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_write(input logic [31:0] old, input logic [31:0] dat,
                                             input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] idx);
    case (idx)
      A_OUT:   return m_out;
      A_DIR:   return m_dir;
      A_IN:    return m_sync[0];
      A_CNT:   return m_cnt;
      A_CMP:   return m_cmp;
      A_CTL:   return {29'd0, m_ctrl};
      A_STS:   return {31'd0, m_status};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_out = '0; m_dir = RDIR; m_cnt = '0; m_cmp = 32'hFFFF_FFFF; m_ctrl = '0;
    m_status = 1'b0; m_irq = 1'b0; m_pend = 1'b0; m_rdata = '0;
    m_sync = {};
    repeat (SYNC) m_sync.push_back(32'd0);
  endtask

  // One bus cycle: drive at the falling edge, check, advance the model at the
  // rising edge.
  task automatic step(input logic r, input logic c, input logic s, input logic w,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
    logic        e_ack, match;
    logic [2:0]  idx;
    logic [31:0] n_out, n_dir, n_cnt, n_cmp, n_rdata;
    logic [2:0]  n_ctrl;
    logic        n_status, n_irq, n_pend;
    @(negedge clk);
    rst = r; wb_cyc = c; wb_stb = s; wb_we = w; wb_adr = a; wb_dat_in = d; wb_sel = sl;
    gpioin = pins;
    #1;
    e_ack = m_pend && c && !r;
    check("ack", {31'd0, wb_ack}, {31'd0, e_ack});
    check("dat_out", wb_dat_out, e_ack ? m_rdata : 32'd0);
    check("gpioout", gpioout, m_out);
    check("gpiodir", gpiodir, m_dir);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    check("stall", {31'd0, wb_stall}, 32'd0);
    last_ack = wb_ack; last_dat = wb_dat_out; last_irq = irq;
    if (wb_ack) n_acks++;

    idx = a[4:2];
    n_out = m_out; n_dir = m_dir; n_cmp = m_cmp; n_ctrl = m_ctrl; n_rdata = m_rdata;
    n_pend = c && s;
    if (c && s) n_rdata = w ? 32'd0 : m_read(idx);
    match = m_ctrl[0] && (m_cnt == m_cmp);
    n_cnt = m_ctrl[0] ? ((match && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1) : m_cnt;
    n_status = m_status;
    if (c && s && w) begin
      case (idx)
        A_OUT: n_out = lane_write(m_out, d, sl);
        A_DIR: n_dir = lane_write(m_dir, d, sl);
        A_CNT: n_cnt = lane_write(m_cnt, d, sl);
        A_CMP: n_cmp = lane_write(m_cmp, d, sl);
        A_CTL: if (sl[0]) n_ctrl = d[2:0];
        A_STS: if (sl[0] && d[0]) n_status = 1'b0;
        default: ;
      endcase
    end
    if (match) n_status = 1'b1;
    n_irq = m_status && m_ctrl[2];

    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      m_out = n_out; m_dir = n_dir; m_cnt = n_cnt; m_cmp = n_cmp; m_ctrl = n_ctrl;
      m_status = n_status; m_irq = n_irq; m_pend = n_pend; m_rdata = n_rdata;
      m_sync.push_back(pins);
      void'(m_sync.pop_front());
    end
  endtask

  task automatic strobe(input logic w, input logic [2:0] idx, input logic [31:0] d,
                        input logic [3:0] sl);
    step(1'b0, 1'b1, 1'b1, w, {27'd0, idx, 2'b00}, d, sl);
  endtask
  task automatic hold();  step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0); endtask
  task automatic idle();  step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0); endtask
  task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] sl);
    strobe(1'b1, idx, d, sl); hold();
  endtask
  task automatic rd(input logic [2:0] idx);
    strobe(1'b0, idx, '0, '0); hold();
  endtask

  initial begin
    int acks0;
    logic [2:0]  ridx;
    logic [31:0] rdat;

    // Bring the DUT to a known state before any comparison.
    rst = 1'b1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_dat_in = '0;
    wb_sel = '0; gpioin = '0;
    repeat (2) @(posedge clk);
    model_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, '0, 32'hFFFF_FFFF, 4'hF);  // strobe under reset ignored
    idle();
    check("reset_dir", gpiodir, RDIR);
    rd(A_CMP);
    check("reset_cmp", last_dat, 32'hFFFF_FFFF);

    // Partial-lane write to GPIO_OUT and read-back.
    wr(A_OUT, 32'hA5A5_0000, 4'b1100);
    check("gpio_out_lanes", gpioout, 32'hA5A5_0000);
    rd(A_OUT);
    check("gpio_out_read", last_dat, 32'hA5A5_0000);

    // Four back-to-back strobes.
    acks0 = n_acks;
    strobe(1'b1, A_CMP, 32'd10, 4'hF);
    strobe(1'b1, A_CTL, 32'h7, 4'hF);
    strobe(1'b0, A_CNT, '0, '0);
    strobe(1'b0, A_CTL, '0, '0);
    hold();
    check("b2b_ctrl_read", last_dat, 32'h7);
    check("b2b_ack_count", n_acks - acks0, 4);

    // Match with auto-clear and interrupt.
    wr(A_CNT, 32'd0, 4'hF);
    repeat (13) idle();
    check("match_irq", {31'd0, last_irq}, 32'd1);
    rd(A_STS);
    check("match_status", last_dat, 32'd1);
    rd(A_CNT);
    check("cnt_low", {31'd0, last_dat < 32'd11}, 32'd1);
    wr(A_CTL, 32'h6, 4'h1);
    wr(A_STS, 32'h1, 4'h1);
    idle();
    check("w1c_irq_low", {31'd0, last_irq}, 32'd0);

    // Wrap through zero, interrupt disabled.
    wr(A_CMP, 32'd1, 4'hF);
    wr(A_CNT, 32'hFFFF_FFFE, 4'hF);
    wr(A_CTL, 32'h1, 4'hF);
    repeat (6) idle();
    rd(A_STS);
    check("wrap_status", last_dat, 32'd1);
    check("wrap_irq", {31'd0, last_irq}, 32'd0);

    // Match and W1C in the same cycle: set wins.
    wr(A_CTL, 32'h0, 4'hF);
    wr(A_STS, 32'h1, 4'h1);
    wr(A_CMP, 32'd5, 4'hF);
    wr(A_CNT, 32'd5, 4'hF);
    strobe(1'b1, A_CTL, 32'h1, 4'hF);
    strobe(1'b1, A_STS, 32'h1, 4'h1);
    hold();
    rd(A_STS);
    check("set_beats_w1c", last_dat, 32'd1);

    // Counter write in a match cycle overrides auto-clear.
    wr(A_CTL, 32'h0, 4'hF);
    wr(A_CNT, 32'd5, 4'hF);
    strobe(1'b1, A_CTL, 32'h3, 4'hF);
    strobe(1'b1, A_CNT, 32'h1234, 4'hF);
    strobe(1'b1, A_CTL, 32'h0, 4'hF);
    hold();
    rd(A_CNT);
    check("cnt_write_wins", last_dat, 32'h1235);

    // Dropped cycle: no ack, but the write still lands.
    strobe(1'b1, A_OUT, 32'h0000_0011, 4'hF);
    idle();
    check("dropped_ack", {31'd0, last_ack}, 32'd0);
    check("dropped_write", gpioout, 32'h0000_0011);
    wr(A_RSV, 32'hDEAD_BEEF, 4'hF);
    rd(A_RSV);
    check("reserved_read", last_dat, 32'd0);

    // GPIO_IN through the synchroniser.
    pins = 32'hCAFE_F00D;
    repeat (3) idle();
    rd(A_IN);
    check("gpio_in", last_dat, 32'hCAFE_F00D);

    // Reset in the middle of a transaction.
    wr(A_CTL, 32'h7, 4'hF);
    strobe(1'b0, A_OUT, '0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    hold();
    check("rst_ack", {31'd0, last_ack}, 32'd0);
    check("rst_out", gpioout, 32'd0);
    check("rst_dir", gpiodir, RDIR);
    check("rst_irq", {31'd0, last_irq}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      ridx = 3'($urandom_range(0, 7));
      case (ridx)
        A_CNT, A_CMP: rdat = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
        A_STS, A_CTL: rdat = $urandom_range(0, 15);
        default:      rdat = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) pins = $urandom;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
           {$urandom_range(0, 255), 19'($urandom), ridx, 2'($urandom)},
           rdat, 4'($urandom));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
